// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART constants and the receiver FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int UART_DATA_BITS          = 8;
  localparam int UART_OVERSAMPLE_DEFAULT = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_state_e;

endpackage
`default_nettype wire

// File: rtl/signal_synchroniser.sv
`default_nettype none
// ============================================================================
// Module      : signal_synchroniser
// Description : Flop chain that brings an asynchronous level into clk domain.
// Revision    : 1.0 - initial release
// ============================================================================
module signal_synchroniser #(
  parameter int   STAGES      = 2,
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= {STAGES{RESET_VALUE}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/uart_rx_deserialiser.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_deserialiser
// Description : Oversampling 8N1 UART receiver; one byte or error per frame.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_deserialiser
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE  = UART_OVERSAMPLE_DEFAULT,
  parameter int SCALE_WIDTH = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [SCALE_WIDTH-1:0]    clockScale,
  input  logic                      rx,
  output logic [UART_DATA_BITS-1:0] dataOut,
  output logic                      dataValid,
  output logic                      framingError,
  output logic                      busy
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);

  logic rx_s;

  uart_state_e               state_q,    state_d;
  logic [SCALE_WIDTH-1:0]    presc_q,    presc_d;
  logic [SCALE_WIDTH-1:0]    scale_q,    scale_d;
  logic [TICK_W-1:0]         tick_cnt_q, tick_cnt_d;
  logic [2:0]                bit_cnt_q,  bit_cnt_d;
  logic [UART_DATA_BITS-1:0] shift_q,    shift_d;
  logic [UART_DATA_BITS-1:0] data_q,     data_d;
  logic                      valid_q,    valid_d;
  logic                      ferr_q,     ferr_d;
  logic                      busy_q,     busy_d;
  logic                      tick;

  // Line idles high, so the chain resets to 1 to avoid a phantom start bit.
  signal_synchroniser #(
    .STAGES      (SYNC_STAGES),
    .RESET_VALUE (1'b1)
  ) u_rx_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  assign tick = (presc_q == scale_q);

  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    scale_d    = scale_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    ferr_d     = 1'b0;

    if (state_q != IDLE) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      if (tick) begin
        tick_cnt_d = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + 1'b1;
      end
    end

    unique case (state_q)
      IDLE: begin
        presc_d    = '0;
        tick_cnt_d = '0;
        if (!rx_s) begin
          state_d = START;
          scale_d = clockScale;
        end
      end
      START: begin
        if (tick && tick_cnt_q == TICK_HALF) begin
          state_d   = rx_s ? IDLE : DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (tick && tick_cnt_q == TICK_LAST) begin
          shift_d   = {rx_s, shift_q[UART_DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (tick && tick_cnt_q == TICK_LAST) begin
          if (rx_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BREAK;
          end
        end
      end
      BREAK: begin
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_d != state_q) begin
      tick_cnt_d = '0;
    end

    // Disabling abandons the frame silently; the last good byte stays visible.
    if (!enable) begin
      state_d    = IDLE;
      presc_d    = '0;
      tick_cnt_d = '0;
      data_d     = data_q;
      valid_d    = 1'b0;
      ferr_d     = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      presc_q    <= '0;
      scale_q    <= '0;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      scale_q    <= scale_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      busy_q     <= busy_d;
    end
  end

  assign dataOut      = data_q;
  assign dataValid    = valid_q;
  assign framingError = ferr_q;
  assign busy         = busy_q;

endmodule
`default_nettype wire
